// File: rtl/sd_block_rx.sv
// sd_block_rx: receive-side data stage for SDHC single-block reads in SPI mode.
// Scans the MISO byte stream for the start token, captures one block into an
// internal buffer, checks the trailing CRC16-CCITT and reports status.
//
// Ports:
//   clk          single clock (SPI byte-engine domain)
//   reset        synchronous, active-high
//   start        one-cycle pulse arming reception; ignored while busy
//   rx_valid     one-cycle strobe per received byte
//   rx_byte      received byte, valid with rx_valid
//   busy         high in every state except IDLE
//   done         one-cycle pulse at block completion (pass or fail)
//   crc_ok       received CRC matched the computed CRC
//   timeout_err  no start token within TOKEN_TIMEOUT polled bytes
//   token_err    data-error token received
//   err_token    captured data-error token value
//   rd_addr      buffer read address
//   rd_data      buffer byte at rd_addr, one cycle latency, read-before-write
module sd_block_rx #(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned TOKEN_TIMEOUT = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  output logic                           busy,
  output logic                           done,
  output logic                           crc_ok,
  output logic                           timeout_err,
  output logic                           token_err,
  output logic [7:0]                     err_token,
  input  logic [$clog2(BLOCK_BYTES)-1:0] rd_addr,
  output logic [7:0]                     rd_data
);

  localparam int unsigned AW = $clog2(BLOCK_BYTES);
  localparam int unsigned PW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [7:0]  START_TOKEN = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TOKEN,
    S_DATA,
    S_CRC_HI,
    S_CRC_LO
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [PW-1:0] poll_inc;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    crc_hi_q, crc_hi_d;
  logic          busy_d, done_d, crc_ok_d, timeout_err_d, token_err_d;
  logic [7:0]    err_token_d;
  logic          buf_we;
  logic          is_err_token;

  logic [7:0]    buf_mem [BLOCK_BYTES];

  // Byte-wise CRC16-CCITT update (poly 0x1021, MSB first)
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  assign poll_inc     = poll_q + PW'(1);
  // Data-error token: upper nibble zero, lower nibble nonzero
  assign is_err_token = (rx_byte[7:4] == 4'h0) && (rx_byte[3:0] != 4'h0);

  // State and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      poll_q      <= '0;
      crc_q       <= 16'h0000;
      crc_hi_q    <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      timeout_err <= 1'b0;
      token_err   <= 1'b0;
      err_token   <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      crc_q       <= crc_d;
      crc_hi_q    <= crc_hi_d;
      busy        <= busy_d;
      done        <= done_d;
      crc_ok      <= crc_ok_d;
      timeout_err <= timeout_err_d;
      token_err   <= token_err_d;
      err_token   <= err_token_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    poll_d        = poll_q;
    crc_d         = crc_q;
    crc_hi_d      = crc_hi_q;
    done_d        = 1'b0;
    crc_ok_d      = crc_ok;
    timeout_err_d = timeout_err;
    token_err_d   = token_err;
    err_token_d   = err_token;
    buf_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          crc_ok_d      = 1'b0;
          timeout_err_d = 1'b0;
          token_err_d   = 1'b0;
          err_token_d   = 8'h00;
          idx_d         = '0;
          poll_d        = '0;
          crc_d         = 16'h0000;
          state_d       = S_WAIT_TOKEN;
        end
      end

      S_WAIT_TOKEN: begin
        if (rx_valid) begin
          if (rx_byte == START_TOKEN) begin
            state_d = S_DATA;
          end else if (is_err_token) begin
            token_err_d = 1'b1;
            err_token_d = rx_byte;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == PW'(TOKEN_TIMEOUT)) begin
              timeout_err_d = 1'b1;
              done_d        = 1'b1;
              state_d       = S_IDLE;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          crc_d  = crc16_byte(crc_q, rx_byte);
          idx_d  = idx_q + AW'(1);
          if (idx_q == AW'(BLOCK_BYTES - 1)) begin
            state_d = S_CRC_HI;
          end
        end
      end

      S_CRC_HI: begin
        if (rx_valid) begin
          crc_hi_d = rx_byte;
          state_d  = S_CRC_LO;
        end
      end

      S_CRC_LO: begin
        if (rx_valid) begin
          crc_ok_d = ({crc_hi_q, rx_byte} == crc_q);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Block buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (buf_we && !reset) begin
      buf_mem[idx_q] <= rx_byte;
    end
  end

  // Registered read port; nonblocking write gives read-before-write
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= buf_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sd_block_rx.sv
// tb_sd_block_rx: directed self-checking bench for sd_block_rx.
// DUT is built with TOKEN_TIMEOUT=16 so the poll timeout is reachable quickly.
module tb_sd_block_rx;

  localparam int unsigned BB = 512;
  localparam int unsigned TT = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       timeout_err;
  logic       token_err;
  logic [7:0] err_token;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;

  int errors;
  int checks;

  logic [7:0] blk [BB];

  sd_block_rx #(
    .BLOCK_BYTES  (BB),
    .TOKEN_TIMEOUT(TT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .timeout_err(timeout_err),
    .token_err  (token_err),
    .err_token  (err_token),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Bit-serial CRC16-CCITT reference over blk[]
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < int'(BB); i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ blk[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Token, block from blk[], CRC; the final byte never has a trailing gap
  task automatic send_block(input logic [15:0] crc, input int maxgap);
    send(8'hFE, $urandom_range(0, maxgap));
    for (int i = 0; i < int'(BB); i++) send(blk[i], $urandom_range(0, maxgap));
    send(crc[15:8], $urandom_range(0, maxgap));
    send(crc[7:0], 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (crc_ok !== 1'b0) begin errors++; $display("FAIL reset_crc_ok got %b want 0", crc_ok); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
    checks++; if (token_err !== 1'b0) begin errors++; $display("FAIL reset_token_err got %b want 0", token_err); end
    checks++; if (err_token !== 8'h00) begin errors++; $display("FAIL reset_err_token got %h want 00", err_token); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_zero_block();
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'h00;
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_after_start got %b want 1", busy); end
    repeat (3) send(8'hFF, 0);
    send_block(16'h0000, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL zero_crc_ok got %b want 1", crc_ok); end
    checks++; if (token_err !== 1'b0) begin errors++; $display("FAIL zero_token_err got %b want 0", token_err); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end got %b want 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_one_cycle got %b want 0", done); end
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL zero_crc_ok_held got %b want 1", crc_ok); end
    for (int a = 0; a < int'(BB); a++) begin
      rd_addr = 9'(a);
      step();
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL zero_read addr %0d got %h want 00", a, rd_data); end
    end
  endtask

  task automatic test_ff_block();
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'hFF;
    do_start();
    send_block(16'h7FA1, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ff_done got %b want 1", done); end
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL ff_crc_ok got %b want 1", crc_ok); end
    step();
    do_start();
    checks++; if (crc_ok !== 1'b0) begin errors++; $display("FAIL ff_crc_ok_cleared got %b want 0", crc_ok); end
    send_block(16'h7FA0, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ffbad_done got %b want 1", done); end
    checks++; if (crc_ok !== 1'b0) begin errors++; $display("FAIL ffbad_crc_ok got %b want 0", crc_ok); end
    step();
  endtask

  task automatic test_ramp(input int maxgap);
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'(i);
    do_start();
    send_block(crc_model(), maxgap);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ramp_done gap%0d got %b want 1", maxgap, done); end
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL ramp_crc_ok gap%0d got %b want 1", maxgap, crc_ok); end
    rd_addr = 9'h000;
    step();
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ramp_rd0 got %h want 00", rd_data); end
    rd_addr = 9'h1FF;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ramp_rd_latency got %h want 00", rd_data); end
    step();
    checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL ramp_rd1ff got %h want ff", rd_data); end
    rd_addr = 9'h0AB;
    step();
    checks++; if (rd_data !== 8'hAB) begin errors++; $display("FAIL ramp_rd0ab got %h want ab", rd_data); end
  endtask

  task automatic test_timeout();
    do_start();
    for (int i = 0; i < int'(TT) - 1; i++) send(8'hFF, i % 3);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_early got %b want 1", busy); end
    send(8'hFF, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done got %b want 1", done); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_held got %b want 1", timeout_err); end
  endtask

  task automatic test_token_err();
    do_start();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tokerr_timeout_cleared got %b want 0", timeout_err); end
    send(8'hFF, 0);
    send(8'hFF, 1);
    send(8'h05, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tokerr_done got %b want 1", done); end
    checks++; if (token_err !== 1'b1) begin errors++; $display("FAIL tokerr_flag got %b want 1", token_err); end
    checks++; if (err_token !== 8'h05) begin errors++; $display("FAIL tokerr_value got %h want 05", err_token); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tokerr_busy got %b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'(i) ^ 8'h5A;
    do_start();
    send(8'hFE, 0);
    for (int i = 0; i < 200; i++) send(blk[i], 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    rd_addr = 9'd150;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done_late got %b want 0", done); end
    checks++; if (rd_data !== 8'hCC) begin errors++; $display("FAIL rstmid_kept got %h want cc", rd_data); end
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'(i);
    do_start();
    send_block(crc_model(), 0);
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL rstmid_recover got %b want 1", crc_ok); end
    step();
  endtask

  task automatic test_start_mid();
    logic [15:0] c;
    for (int i = 0; i < int'(BB); i++) blk[i] = ~8'(i);
    c = crc_model();
    do_start();
    send(8'hFE, 0);
    for (int i = 0; i < 100; i++) send(blk[i], 0);
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startmid_busy got %b want 1", busy); end
    for (int i = 100; i < int'(BB); i++) send(blk[i], 0);
    send(c[15:8], 0);
    send(c[7:0], 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL startmid_done got %b want 1", done); end
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL startmid_crc_ok got %b want 1", crc_ok); end
    rd_addr = 9'd100;
    step();
    checks++; if (rd_data !== 8'h9B) begin errors++; $display("FAIL startmid_rd100 got %h want 9b", rd_data); end
  endtask

  task automatic test_back_to_back();
    do_start();
    send(8'h03, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    checks++; if (err_token !== 8'h03) begin errors++; $display("FAIL b2b_err_token got %h want 03", err_token); end
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    checks++; if (token_err !== 1'b0) begin errors++; $display("FAIL b2b_token_err_cleared got %b want 0", token_err); end
    checks++; if (err_token !== 8'h00) begin errors++; $display("FAIL b2b_err_token_cleared got %h want 00", err_token); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got %b want 0", done); end
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'(i);
    send_block(crc_model(), 0);
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_crc_ok got %b want 1", crc_ok); end
    step();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rd_addr  = 9'h000;
    #1;
    test_reset();
    test_zero_block();
    test_ff_block();
    test_ramp(0);
    test_ramp(5);
    test_timeout();
    test_token_err();
    test_reset_mid();
    test_start_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_block_rx.md
# sd_block_rx

Receive-side data stage for SDHC single-block reads in SPI mode. Sits directly downstream of the SPI byte engine that drives SD_CMD and samples SD_DAT[0]. After a read command is issued, it scans the incoming MISO byte stream for the start token, captures the 512-byte data block into an internal buffer, and checks the trailing CRC16. It then reports status and exposes the buffer through a synchronous read port for the consumer (LED/debug logic or a later storage stage).

## Interface
- BLOCK_BYTES, 512, data bytes per block; fixed by SDHC, power of two.
- TOKEN_TIMEOUT, 4096, maximum number of polled bytes accepted before the start token.
- clk  in  1  single clock for the block, the SPI byte-engine clock domain.
- reset  in  1  synchronous, active-high; all state and outputs return to reset values on the next clk edge.
- start  in  1  one-cycle pulse that arms reception of one block; ignored while busy=1.
- rx_valid  in  1  one-cycle strobe, one per byte received from MISO.
- rx_byte  in  8  received byte, MSB first on the wire; valid when rx_valid=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the block completes, whether it passes or fails.
- crc_ok  out  1  received CRC matches the computed CRC; held until next start.
- timeout_err  out  1  no start token arrived within TOKEN_TIMEOUT bytes; held until next start.
- token_err  out  1  data-error token received; held until next start.
- err_token  out  8  captured data-error token value; held until next start.
- rd_addr  in  $clog2(BLOCK_BYTES)  buffer read address.
- rd_data  out  8  buffer byte at rd_addr, registered with 1-cycle latency.

## Operation
- Reset values: busy=0, done=0, crc_ok=0, timeout_err=0, token_err=0, err_token=0x00, rd_data=0x00, state=IDLE. Buffer RAM is not cleared.
- State machine:
  - IDLE: start=1 clears crc_ok, timeout_err, token_err, err_token, the byte index, the poll counter, and the CRC accumulator (0x0000); moves to WAIT_TOKEN.
  - WAIT_TOKEN, handled per rx_valid:
    - 0xFE: go to DATA.
    - Upper nibble 0000 with nonzero lower nibble: data-error token. Set token_err=1, capture err_token, pulse done, return to IDLE.
    - Any other value (including 0xFF): increment the poll counter. When the counter reaches TOKEN_TIMEOUT, set timeout_err=1, pulse done, return to IDLE.
  - DATA: each rx_valid writes rx_byte to buf[index], updates the CRC16-CCITT (poly 0x1021, init 0x0000, MSB first, byte-wise in one cycle), and increments index. The write of byte BLOCK_BYTES-1 moves the FSM to CRC_HI.
  - CRC_HI: the next rx_valid latches the received CRC[15:8].
  - CRC_LO: the next rx_valid latches CRC[7:0] and compares against the accumulator. crc_ok=(match). Pulse done; return to IDLE.
- busy=1 in every state except IDLE.
- rx_valid in IDLE is ignored. Cycles without rx_valid never advance the FSM or the counters.
- The index is width $clog2(BLOCK_BYTES) and never wraps mid-block; the transition out of DATA occurs exactly at index BLOCK_BYTES-1.
- The read port is usable in any state. If rd_addr equals the address being written in the same cycle, rd_data returns the old content (read-before-write).
- start while busy=1 has no effect. start coincident with reset: reset wins.
- reset mid-block abandons the transfer with no done pulse. Buffer bytes already written remain.

## Timing
- start at cycle N: busy=1 at N+1.
- Token 0xFE with rx_valid at cycle T: a data byte is accepted at T+1 at the earliest.
- The final CRC byte's rx_valid at cycle C: done=1 and crc_ok valid at C+1, busy=0 at C+1. done is high exactly one cycle.
- Error termination (timeout or error token) on the rx_valid at cycle E: done, the error flag, and busy=0 all appear at E+1.
- rd_addr at cycle R: rd_data valid at R+1.
- Back-to-back operation: start is accepted in the cycle done is high, since the FSM is already in IDLE. Status flags clear at that start.
- rx_valid may be asserted on consecutive cycles, giving full-rate reception with no stall.

## Test plan
- 3×0xFF, then 0xFE, 512×0x00, CRC 0x00 0x00 → done after the last byte, crc_ok=1, token_err=0, timeout_err=0; rd_addr=0..511 returns 0x00.
- 0xFE, then 512×0xFF, CRC 0x7F 0xA1 → crc_ok=1. Repeat with CRC 0x7F 0xA0 → crc_ok=0 and done still pulses.
- 0xFE, then bytes i[7:0] for i=0..511 with the reference-model CRC → crc_ok=1; rd_addr=0x1FF returns 0xFF with 1-cycle latency; rx_valid gaps of 0–5 cycles produce an identical result.
- Continuous 0xFF with TOKEN_TIMEOUT=16 → timeout_err=1 on the 16th byte's following cycle, done pulses, busy=0. 0x05 after two 0xFF → token_err=1, err_token=0x05.
- Reset asserted after 200 data bytes → next cycle busy=0 with no done pulse; a new start plus a full block completes with crc_ok=1.
- start pulsed mid-DATA → ignored with no index reset; start in the done cycle → busy=1 next cycle and flags cleared.
